// File: rtl/prim_gate_arbiter.sv
// prim_gate_arbiter: 4-way round-robin arbiter serving bitwise gate ops.
// Optional macro PRIM_GATE_ARB_ERR_EN adds the err port for opcode 11.
module prim_gate_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0][1:0]       op,
    input  logic [3:0][WIDTH-1:0] a,
    input  logic [3:0][WIDTH-1:0] b,
    output logic [3:0]            gnt,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res,
    output logic [1:0]            res_id
`ifdef PRIM_GATE_ARB_ERR_EN
    ,
    output logic                  err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_win;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_gnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic [1:0]       r_res_id;

    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_win;
    logic [WIDTH-1:0] w_res;

`ifdef PRIM_GATE_ARB_ERR_EN
    logic             r_err;
    logic             w_err;
    assign err = r_err;
`endif

    assign gnt       = r_gnt;
    assign res_valid = r_valid;
    assign res       = r_res;
    assign res_id    = r_res_id;

    // Rotate requests so bit 0 is the requester at the round-robin pointer
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < 4; i++) begin
            w_rot[i] = req[2'(r_ptr + 2'(i))];
        end
    end

    // First requester at or above the pointer, with wrap 3->0
    always_comb begin
        w_off = 2'd3;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end
        w_win = r_ptr + w_off;
    end

    // Gate evaluation of the captured operands
    always_comb begin
        w_res = ~r_a;
`ifdef PRIM_GATE_ARB_ERR_EN
        w_err = 1'b0;
`endif
        case (r_op)
            2'b00: w_res = r_a & r_b;
            2'b01: w_res = ~(r_a & r_b);
            2'b10: w_res = ~r_a;
            default: begin
`ifdef PRIM_GATE_ARB_ERR_EN
                w_res = '0;
                w_err = 1'b1;
`else
                w_res = ~r_a;
`endif
            end
        endcase
    end

    // Control FSM: grant, evaluate, hold result until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_win    <= 2'd0;
            r_op     <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_gnt    <= 4'd0;
            r_valid  <= 1'b0;
            r_res    <= '0;
            r_res_id <= 2'd0;
`ifdef PRIM_GATE_ARB_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_gnt <= 4'd0;
            unique case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_win   <= w_win;
                        r_op    <= op[w_win];
                        r_a     <= a[w_win];
                        r_b     <= b[w_win];
                        r_gnt   <= 4'd1 << w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res    <= w_res;
                    r_res_id <= r_win;
                    r_valid  <= 1'b1;
`ifdef PRIM_GATE_ARB_ERR_EN
                    r_err    <= w_err;
`endif
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
`ifdef PRIM_GATE_ARB_ERR_EN
                        r_err   <= 1'b0;
`endif
                        r_ptr   <= r_win + 2'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prim_gate_arbiter.sv
// tb_prim_gate_arbiter: randomized bench with a transaction-level model
// of the round-robin gate arbiter.
module tb_prim_gate_arbiter;

    localparam int W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         req = '0;
    logic [3:0][1:0]    op = '0;
    logic [3:0][W-1:0]  a = '0;
    logic [3:0][W-1:0]  b = '0;
    logic [3:0]         gnt;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [W-1:0]       res;
    logic [1:0]         res_id;
`ifdef PRIM_GATE_ARB_ERR_EN
    logic               err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int m_ptr = 0;
    int last_gnt_cyc = 0;
    logic [W-1:0] last_res = '0;
    logic [1:0]   last_id = '0;

    prim_gate_arbiter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .op(op),
        .a(a),
        .b(b),
        .gnt(gnt),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res(res),
        .res_id(res_id)
`ifdef PRIM_GATE_ARB_ERR_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(logic [1:0] o, logic [W-1:0] x,
                                           logic [W-1:0] y);
        case (o)
            2'd0: return x & y;
            2'd1: return ~(x & y);
            2'd2: return ~x;
`ifdef PRIM_GATE_ARB_ERR_EN
            default: return '0;
`else
            default: return ~x;
`endif
        endcase
    endfunction

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full transaction; returns winner index
    task automatic serve(input logic [3:0] rq, input int stall,
                         input bit keep_req, input bit early_rdy,
                         output int w);
        logic [W-1:0] exp;
        logic [3:0]   eg;
        bit           exp_err;
        req = rq;
        w = pick(rq, m_ptr);
        exp = model(op[w], a[w], b[w]);
        exp_err = (op[w] == 2'd3);
        eg = 4'(1 << w);
        tick();
        n_vec++;
        if (gnt !== eg || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL grant: gnt=%b valid=%b, required gnt=%b valid=0",
                     gnt, res_valid, eg);
        end
        last_gnt_cyc = cyc;
        if (!keep_req) req[w] = 1'b0;
        a[w] = W'($urandom);
        b[w] = W'($urandom);
        res_ready = early_rdy;
        tick();
        n_vec++;
        if (res_valid !== 1'b1 || res !== exp || res_id !== 2'(w) || gnt !== 4'd0) begin
            n_err++;
            $display("FAIL result: valid=%b res=%h id=%0d gnt=%b, required 1 %h %0d 0000",
                     res_valid, res, res_id, gnt, exp, w);
        end
`ifdef PRIM_GATE_ARB_ERR_EN
        n_vec++;
        if (err !== exp_err) begin
            n_err++;
            $display("FAIL err_flag: err=%b, required %b", err, exp_err);
        end
`endif
        for (int s = 0; s < stall; s++) begin
            res_ready = 1'b0;
            tick();
            n_vec++;
            if (res_valid !== 1'b1 || res !== exp || res_id !== 2'(w) || gnt !== 4'd0) begin
                n_err++;
                $display("FAIL hold: valid=%b res=%h id=%0d gnt=%b, required 1 %h %0d 0000",
                         res_valid, res, res_id, gnt, exp, w);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        m_ptr = (w + 1) % 4;
        last_res = exp;
        last_id = 2'(w);
        n_vec++;
        if (res_valid !== 1'b0 || res !== exp || res_id !== 2'(w) || gnt !== 4'd0) begin
            n_err++;
            $display("FAIL accept: valid=%b res=%h id=%0d gnt=%b, required 0 %h %0d 0000",
                     res_valid, res, res_id, gnt, exp, w);
        end
`ifdef PRIM_GATE_ARB_ERR_EN
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
`endif
    endtask

    task automatic idle_check();
        req = 4'd0;
        res_ready = 1'($urandom);
        tick();
        res_ready = 1'b0;
        n_vec++;
        if (gnt !== 4'd0 || res_valid !== 1'b0 || res !== last_res || res_id !== last_id) begin
            n_err++;
            $display("FAIL idle: gnt=%b valid=%b res=%h id=%0d, required 0000 0 %h %0d",
                     gnt, res_valid, res, res_id, last_res, last_id);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        last_res = '0;
        last_id = '0;
    endtask

    task automatic test_reset();
        req = 4'hF;
        res_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'd0 || res_valid !== 1'b0 || res !== '0 || res_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset: gnt=%b valid=%b res=%h id=%0d, required all zero",
                     gnt, res_valid, res, res_id);
        end
`ifdef PRIM_GATE_ARB_ERR_EN
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err: err=%b, required 0", err);
        end
`endif
        req = 4'd0;
        res_ready = 1'b0;
        rst = 1'b0;
        m_ptr = 0;
        idle_check();
        idle_check();
    endtask

    task automatic test_basic();
        int w;
        op[0] = 2'b00;
        a[0] = 8'hF0;
        b[0] = 8'h3C;
        serve(4'b0001, 0, 1'b0, 1'b1, w);
        n_vec++;
        if (last_res !== 8'h30 || w != 0) begin
            n_err++;
            $display("FAIL basic_const: res=%h id=%0d, required 30 0", last_res, w);
        end
        idle_check();
    endtask

    task automatic test_rr();
        int w;
        int prev;
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op[i] = 2'b01;
            a[i] = W'($urandom);
            b[i] = W'($urandom);
        end
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            serve(4'hF, 0, 1'b1, 1'b1, w);
            n_vec++;
            if (4'(1 << w) !== order[i]) begin
                n_err++;
                $display("FAIL rr_order: step %0d gnt=%b, required %b",
                         i, 4'(1 << w), order[i]);
            end
            if (i > 0) begin
                n_vec++;
                if (last_gnt_cyc - prev != 3) begin
                    n_err++;
                    $display("FAIL rr_rate: spacing=%0d, required 3",
                             last_gnt_cyc - prev);
                end
            end
            prev = last_gnt_cyc;
        end
        req = 4'd0;
        idle_check();
    endtask

    task automatic test_backpressure();
        int w;
        op[2] = 2'b10;
        a[2] = 8'hA5;
        b[2] = W'($urandom);
        serve(4'b0100, 4, 1'b1, 1'b0, w);
        req = 4'd0;
        n_vec++;
        if (last_res !== 8'h5A || w != 2) begin
            n_err++;
            $display("FAIL bp_const: res=%h id=%0d, required 5a 2", last_res, w);
        end
        idle_check();
    endtask

    task automatic test_reset_resp();
        int w;
        req = 4'b0010;
        tick();
        req = 4'd0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        last_res = '0;
        last_id = '0;
        n_vec++;
        if (res_valid !== 1'b0 || gnt !== 4'd0 || res !== '0 || res_id !== 2'd0) begin
            n_err++;
            $display("FAIL rst_resp: valid=%b gnt=%b res=%h id=%0d, required all zero",
                     res_valid, gnt, res, res_id);
        end
        idle_check();
        serve(4'b1001, 0, 1'b0, 1'b0, w);
        req = 4'd0;
        serve(4'b1000, 1, 1'b0, 1'b0, w);
        idle_check();
    endtask

    task automatic test_reserved();
        int w;
        op[1] = 2'b11;
        a[1] = 8'hFF;
        b[1] = W'($urandom);
        serve(4'b0010, 1, 1'b0, 1'b0, w);
        n_vec++;
        if (last_res !== 8'h00) begin
            n_err++;
            $display("FAIL reserved_const: res=%h, required 00", last_res);
        end
        idle_check();
    endtask

    task automatic test_random();
        int w;
        logic [3:0] rq;
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++) begin
                op[j] = 2'($urandom);
                a[j] = W'($urandom);
                b[j] = W'($urandom);
            end
            rq = 4'($urandom);
            if (rq == 4'd0) begin
                idle_check();
            end else begin
                serve(rq, int'($urandom_range(0, 3)), 1'b0,
                      1'($urandom), w);
            end
        end
        req = 4'd0;
        idle_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_basic();
        test_rr();
        test_backpressure();
        test_reset_resp();
        test_reserved();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prim_gate_arbiter.md
PRIM_GATE_ARBITER -- requirements
Module: prim_gate_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH  8  operand/result bit width, legal range 1..64
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock, rising edge
  rst  input  1  reset, synchronous, active-high
  req  input  4  per-requester request, held until granted
  op  input  4x2  per-requester opcode: 00 AND, 01 NAND, 10 NOT, 11 reserved
  a  input  4xWIDTH  per-requester operand A
  b  input  4xWIDTH  per-requester operand B (ignored for NOT)
  gnt  output  4  one-hot grant, one-cycle pulse
  res_valid  output  1  result valid
  res_ready  input  1  consumer accepts result
  res  output  WIDTH  result
  res_id  output  2  index of requester owning res
  err  output  1  reserved-opcode flag (present only with PRIM_GATE_ARB_ERR_EN)
REQ-003 The block SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, EXEC, RESP; the block SHALL serve exactly one request at a time.
REQ-005 IDLE with req==0: SHALL stay IDLE, all outputs unchanged except gnt=0.
REQ-006 IDLE with req!=0 at edge N: SHALL select the winner round-robin, starting search at pointer ptr, upward with wrap 3->0; SHALL capture op/a/b of the winner; SHALL drive gnt=onehot(winner) during cycle N+1 only; next state EXEC.
REQ-007 EXEC at edge N+1: SHALL compute res bitwise (AND: a&b, NAND: ~(a&b), NOT: ~a); SHALL assert res_valid, res, res_id=winner from cycle N+2; next state RESP.
REQ-008 RESP: res_valid, res, res_id SHALL hold stable until an edge with res_ready=1; on that edge res_valid SHALL clear, ptr SHALL become (winner+1) mod 4, next state IDLE.
REQ-009 res_ready asserted outside RESP SHALL be ignored; req SHALL be ignored in EXEC and RESP.
REQ-010 Minimum request-to-request throughput SHALL be one result per 3 cycles; the first req-seen-to-res_valid latency SHALL be 2 cycles.
REQ-011 A requester deasserting req before gnt SHALL simply not be considered at the next IDLE evaluation; no partial capture.
REQ-012 ptr SHALL advance only on result acceptance, never on reset or idle cycles.
REQ-013 res and res_id SHALL retain their last values after acceptance until the next EXEC.

Reset
REQ-014 While rst=1 at an edge: state=IDLE, ptr=0, gnt=0, res_valid=0, res=0, res_id=0, err=0.
REQ-015 Reset in EXEC or RESP SHALL discard the in-flight request without producing res_valid.

Configuration
REQ-016 Macro PRIM_GATE_ARB_ERR_EN defined: port err SHALL exist; opcode 11 SHALL produce res=0 and err=1 coincident with res_valid, cleared on acceptance.
REQ-017 Macro PRIM_GATE_ARB_ERR_EN undefined: port err SHALL be absent; opcode 11 SHALL be evaluated as NOT.

Verification
REQ-018 Scenario: req=0001, op0=00, a0=8'hF0, b0=8'h3C, res_ready=1 -> gnt=0001 at N+1, res=8'h30, res_id=0 at N+2.
REQ-019 Scenario: req=1111 held, res_ready=1, all NAND -> grants in order 0001,0010,0100,1000,0001, one every 3 cycles.
REQ-020 Scenario: op2=10, a2=8'hA5, res_ready=0 for 5 cycles -> res=8'h5A, res_id=2, res_valid held 5 cycles, no gnt until accepted.
REQ-021 Scenario: rst pulsed one cycle while in RESP -> res_valid=0 next cycle, ptr=0, next req=1000 granted normally.
REQ-022 Scenario: op1=11, a1=8'hFF -> with PRIM_GATE_ARB_ERR_EN res=8'h00, err=1; without, res=8'h00 (NOT), no err port.
